// File: rtl/serial_adder_if.sv
// Handshake bundle for the bit-serial adder: operand side (in_*), result side
// (out_*), plus the busy status flag.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  // The producer/consumer environment drives operands and accepts results
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  // The adder itself
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell with a registered carry, processing
// the operands LSB-first, one bit per clock. The visible sum/cout are only
// updated when a whole result is complete, so they stay stable while running.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [WIDTH-1:0] work_sum;
  logic [WIDTH-1:0] work_sum_next;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic [CW-1:0]    count;

  logic             last_bit;
  logic             bit_sum;
  logic             bit_carry;

  assign last_bit  = (count == CW'(WIDTH - 1));
  assign bit_sum   = a_reg[0] ^ b_reg[0] ^ carry;
  assign bit_carry = (a_reg[0] & b_reg[0]) | (carry & (a_reg[0] ^ b_reg[0]));

  // Working sum shifts right with the fresh sum bit entering at the MSB
  always_comb begin
    work_sum_next            = work_sum >> 1;
    work_sum_next[WIDTH-1]   = bit_sum;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: accept in IDLE, run WIDTH bits, wait for the consumer
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid)  state_next = RUN;
      RUN:  if (last_bit)      state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Datapath: capture operands, shift one bit per cycle, publish on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      work_sum <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            carry <= bus.cin;
            count <= '0;
          end
        end
        RUN: begin
          a_reg    <= a_reg >> 1;
          b_reg    <= b_reg >> 1;
          carry    <= bit_carry;
          work_sum <= work_sum_next;
          count    <= count + CW'(1);
          if (last_bit) begin
            sum_reg  <= work_sum_next;
            cout_reg <= bit_carry;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for the bit-serial adder: an 8-bit instance driven from a vector table,
// random operands and hand-written corner sequences, plus 1-bit and 3-bit
// instances swept over every operand combination.
module tb_serial_adder;

  logic clk;
  logic rst_n;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();
  serial_adder_if #(.WIDTH(3)) bus3 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  serial_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    int         hold;
  } vec_t;

  vec_t       vecs [8];
  logic [8:0] exp_q [$];
  logic [8:0] last8;
  int         n_checks;
  int         n_fails;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One 8-bit operation: accept, watch RUN, optional backpressure, consume
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     input logic [8:0] exp, input int hold, input bit poke);
    int n;
    logic [8:0] want;
    n = 0;
    while (!bus8.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready before accept", 32'(bus8.in_ready), 32'd1);
    bus8.a        = av;
    bus8.b        = bv;
    bus8.cin      = cv;
    bus8.in_valid = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    n = 0;
    while (!bus8.out_valid && n < 40) begin
      check("busy in run", 32'(bus8.busy), 32'd1);
      check("outputs held in run", 32'({bus8.cout, bus8.sum}), 32'(last8));
      if (poke && n == 2) begin
        bus8.a        = 8'h00;
        bus8.b        = 8'h00;
        bus8.cin      = 1'b0;
        bus8.in_valid = 1'b1;
      end
      if (poke && n == 3) bus8.in_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    check("latency to out_valid", 32'(n), 32'd8);
    want = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      check("backpressure hold", 32'({bus8.out_valid, bus8.in_ready, bus8.cout, bus8.sum}),
            32'({2'b10, want}));
      @(negedge clk);
    end
    check("result", 32'({bus8.out_valid, bus8.cout, bus8.sum}), 32'({1'b1, want}));
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check("back to idle", 32'({bus8.in_ready, bus8.busy, bus8.out_valid}), 32'd4);
    last8 = want;
  endtask

  // One operation on the narrow instances (w selects 1-bit or 3-bit)
  task automatic small_op(input int w, input int av, input int bv, input int cv);
    int n;
    logic [3:0] got;
    logic [8:0] want;
    logic ovld;
    if (w == 1) begin
      check("w1 in_ready", 32'(bus1.in_ready), 32'd1);
      bus1.a = 1'(av); bus1.b = 1'(bv); bus1.cin = 1'(cv); bus1.in_valid = 1'b1;
    end else begin
      check("w3 in_ready", 32'(bus3.in_ready), 32'd1);
      bus3.a = 3'(av); bus3.b = 3'(bv); bus3.cin = 1'(cv); bus3.in_valid = 1'b1;
    end
    exp_q.push_back(9'(av + bv + cv));
    @(negedge clk);
    bus1.in_valid = 1'b0;
    bus3.in_valid = 1'b0;
    n = 0;
    ovld = (w == 1) ? bus1.out_valid : bus3.out_valid;
    while (!ovld && n < 20) begin
      @(negedge clk);
      n++;
      ovld = (w == 1) ? bus1.out_valid : bus3.out_valid;
    end
    check("small latency", 32'(n), 32'(w));
    got  = (w == 1) ? {2'b00, bus1.cout, bus1.sum} : {bus3.cout, bus3.sum};
    want = exp_q.pop_front();
    check("small result", 32'(got), 32'(want));
    if (w == 1) bus1.out_ready = 1'b1; else bus3.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
    bus3.out_ready = 1'b0;
  endtask

  // Main sequence
  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    n_checks = 0;
    n_fails  = 0;
    last8    = '0;
    rst_n    = 1'b0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    bus3.in_valid = 1'b0; bus3.out_ready = 1'b0; bus3.a = '0; bus3.b = '0; bus3.cin = 1'b0;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 5};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 2};
    vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 0};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0};
    vecs[7] = '{8'h64, 8'h32, 1'b1, 8'h97, 1'b0, 1};

    @(negedge clk);
    check("reset state", 32'({bus8.in_ready, bus8.busy, bus8.out_valid, bus8.cout, bus8.sum}),
          32'({4'b1000, 8'h00}));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", 32'({bus8.in_ready, bus8.busy}), 32'd2);

    for (int i = 0; i < 8; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum}, vecs[i].hold, 1'b0);
    end

    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      op8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'h00, rc}, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] in_valid pulse during RUN must be ignored");
    op8(8'h12, 8'h34, 1'b0, 9'h046, 0, 1'b1);
    @(negedge clk);
    check("no second op accepted", 32'({bus8.in_ready, bus8.busy}), 32'd2);

    $display("[TB] reset in the middle of an operation");
    op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, 0, 1'b0);
    bus8.a = 8'hAB; bus8.b = 8'h11; bus8.cin = 1'b0; bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("busy before reset", 32'(bus8.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'({bus8.out_valid, bus8.busy, bus8.cout, bus8.sum}), 32'd0);
    last8 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after mid-op reset", 32'({bus8.in_ready, bus8.out_valid}), 32'd2);
    op8(8'h01, 8'h01, 1'b0, 9'h002, 0, 1'b0);

    $display("[TB] exhaustive narrow widths");
    for (int av = 0; av < 2; av++)
      for (int bv = 0; bv < 2; bv++)
        for (int cv = 0; cv < 2; cv++)
          small_op(1, av, bv, cv);
    for (int av = 0; av < 8; av++)
      for (int bv = 0; bv < 8; bv++)
        for (int cv = 0; cv < 2; cv++)
          small_op(3, av, bv, cv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
